// File: rtl/pea_firing_scheduler_if.sv
// PEA actor control interface: the scheduler starts firings with invoke/next_instr
// and the actor reports completion (FC) together with the fields of the command it
// decoded (instr, b, N).
interface pea_firing_scheduler_if;
    logic       invoke;
    logic [1:0] next_instr;
    logic       FC;
    logic [7:0] instr;
    logic [4:0] b;
    logic [3:0] N;

    // Scheduler side
    modport master (
        output invoke,
        output next_instr,
        input  FC,
        input  instr,
        input  b,
        input  N
    );

    // PEA actor side
    modport slave (
        input  invoke,
        input  next_instr,
        output FC,
        output instr,
        output b,
        output N
    );
endinterface

// File: rtl/pea_firing_scheduler.sv
// Dataflow firing scheduler for the PEA actor. It checks FIFO populations and free
// space for the actor's current mode, issues a one-cycle invoke, holds next_instr
// stable while the actor fires, waits for FC (with a watchdog), and then chooses
// the next mode from the command the actor just decoded.
module pea_firing_scheduler #(
    parameter int         word_size = 16,
    parameter int         TIMEOUT   = 1024,
    parameter logic [7:0] OP_STP    = 8'h01,
    parameter logic [7:0] OP_EVP    = 8'h02,
    parameter logic [7:0] OP_RST    = 8'h03
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sched_en,
    input  logic [word_size-1:0]     command_pop,
    input  logic [word_size-1:0]     data_pop,
    input  logic [word_size-1:0]     result_free_space,
    input  logic [word_size-1:0]     status_free_space,
    pea_firing_scheduler_if.master   pea,
    output logic                     busy,
    output logic [15:0]              fire_count,
    output logic                     timeout_err
);

    // Wide enough to hold TIMEOUT-1 for any TIMEOUT >= 2.
    localparam int WCW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_INVOKE,
        S_WAIT,
        S_UPDATE,
        S_HALT
    } state_t;

    // The encoding doubles as the next_instr value presented to the actor.
    typedef enum logic [1:0] {
        MODE_CMD  = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_EVAL = 2'b10
    } mode_t;

    state_t         state_reg,       state_next;
    mode_t          mode_reg,        mode_next;
    logic [4:0]     eval_left_reg,   eval_left_next;
    logic [3:0]     n_reg,           n_next;
    logic [WCW-1:0] wait_cnt_reg,    wait_cnt_next;
    logic [15:0]    fire_count_reg,  fire_count_next;
    logic           timeout_err_reg, timeout_err_next;

    logic           cmd_ok;
    logic           load_ok;
    logic           eval_ok;
    logic           enabled;
    logic [4:0]     load_need;
    logic [4:0]     eval_dec;

    // Firing rules for each mode; populations are compared as unsigned values.
    always_comb begin
        load_need = {1'b0, n_reg} + 5'd1;
        cmd_ok    = (command_pop != '0) && (status_free_space != '0);
        load_ok   = (data_pop >= word_size'(load_need));
        eval_ok   = (data_pop != '0) && (result_free_space != '0);
        case (mode_reg)
            MODE_CMD:  enabled = cmd_ok;
            MODE_LOAD: enabled = load_ok;
            MODE_EVAL: enabled = eval_ok;
            default:   enabled = cmd_ok;
        endcase
    end

    // Next-state and datapath update for the scheduler FSM.
    always_comb begin
        state_next       = state_reg;
        mode_next        = mode_reg;
        eval_left_next   = eval_left_reg;
        n_next           = n_reg;
        wait_cnt_next    = wait_cnt_reg;
        fire_count_next  = fire_count_reg;
        timeout_err_next = timeout_err_reg;
        eval_dec         = eval_left_reg - 5'd1;

        case (state_reg)
            S_IDLE: begin
                if (sched_en) begin
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!sched_en) begin
                    state_next = S_IDLE;
                end else if (enabled) begin
                    state_next = S_INVOKE;
                end
            end
            S_INVOKE: begin
                state_next    = S_WAIT;
                wait_cnt_next = '0;
            end
            S_WAIT: begin
                if (pea.FC) begin
                    state_next = S_UPDATE;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                    if (wait_cnt_reg == WCW'(TIMEOUT - 1)) begin
                        state_next       = S_HALT;
                        timeout_err_next = 1'b1;
                    end
                end
            end
            S_UPDATE: begin
                fire_count_next = fire_count_reg + 16'd1;
                case (mode_reg)
                    MODE_LOAD: begin
                        mode_next = MODE_CMD;
                    end
                    MODE_EVAL: begin
                        eval_left_next = eval_dec;
                        mode_next      = (eval_dec == 5'd0) ? MODE_CMD : MODE_EVAL;
                    end
                    default: begin
                        // A command firing: the decoded opcode selects the data phase.
                        if (pea.instr == OP_STP) begin
                            mode_next = MODE_LOAD;
                            n_next    = pea.N;
                        end else if ((pea.instr == OP_EVP) && (pea.b != 5'd0)) begin
                            mode_next      = MODE_EVAL;
                            eval_left_next = pea.b;
                        end else if (pea.instr == OP_RST) begin
                            mode_next = MODE_CMD;
                        end else begin
                            mode_next = MODE_CMD;
                        end
                    end
                endcase
                state_next = sched_en ? S_CHECK : S_IDLE;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any firing in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= S_IDLE;
            mode_reg        <= MODE_CMD;
            eval_left_reg   <= '0;
            n_reg           <= '0;
            wait_cnt_reg    <= '0;
            fire_count_reg  <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            mode_reg        <= mode_next;
            eval_left_reg   <= eval_left_next;
            n_reg           <= n_next;
            wait_cnt_reg    <= wait_cnt_next;
            fire_count_reg  <= fire_count_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign pea.invoke     = (state_reg == S_INVOKE);
    assign pea.next_instr = mode_reg;
    assign busy           = (state_reg == S_INVOKE) || (state_reg == S_WAIT) ||
                            (state_reg == S_UPDATE);
    assign fire_count     = fire_count_reg;
    assign timeout_err    = timeout_err_reg;

endmodule
